// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
// Shared definitions for the encoder sampler: controller state encoding, the
// field positions of the counter configuration word and a helper that builds
// that word from a state and the latched mode.
// Ports: none (package).
// -----------------------------------------------------------------------------
package encoder_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StClear,
      StSettle,
      StRun
   } state_e;

   localparam int unsigned MODE_LSB  = 0;
   localparam int unsigned EN_LSB    = 2;
   localparam int unsigned CLR_LSB   = 4;
   localparam int unsigned SEL_WIDTH = 33;

   // Configuration word for the counter while the controller sits in st.
   function automatic logic [SEL_WIDTH-1:0] sel_word(state_e st, logic [1:0] m);
      logic [SEL_WIDTH-1:0] w;
      w = '0;
      w[MODE_LSB +: 2] = m;
      if (st == StSettle || st == StRun) begin
         w[EN_LSB +: 2] = 2'b11;
      end
      if (st == StClear) begin
         w[CLR_LSB +: 2] = 2'b11;
      end
      return w;
   endfunction

endpackage

// File: rtl/encoder_sampler_if.sv
// -----------------------------------------------------------------------------
// encoder_sampler_if
// Valid/ready channel carrying the per-period velocity pair.
// Signals:
//   vel0, vel1 : signed deltas for channel 0 / 1 (COUNT_WIDTH bits)
//   vel_valid  : velocity pair available (producer)
//   vel_ready  : consumer accepts the pair (consumer)
// Modports: master = producer (sampler), slave = consumer.
// -----------------------------------------------------------------------------
interface encoder_sampler_if #(
   parameter int unsigned COUNT_WIDTH = 16
) ();

   logic [COUNT_WIDTH-1:0] vel0;
   logic [COUNT_WIDTH-1:0] vel1;
   logic                   vel_valid;
   logic                   vel_ready;

   modport master (output vel0, output vel1, output vel_valid, input vel_ready);
   modport slave  (input vel0, input vel1, input vel_valid, output vel_ready);

endinterface

// File: rtl/enc_channel_delta.sv
// -----------------------------------------------------------------------------
// enc_channel_delta
// One counter channel: remembers the previous snapshot and produces the
// modular difference to the current counter value. With
// ENCODER_SAMPLER_POS_ACCUM_EN defined it also keeps a 32-bit signed position
// accumulator; otherwise o_pos is tied to 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sample     : take a snapshot (prev <= i_q, accumulate delta)
//   init       : clear prev (and the accumulator)
//   i_q        : counter value
//   o_delta    : i_q - prev, modulo 2^COUNT_WIDTH
//   o_pos      : accumulated position
// -----------------------------------------------------------------------------
module enc_channel_delta #(
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sample,
   input  logic                   init,
   input  logic [COUNT_WIDTH-1:0] i_q,
   output logic [COUNT_WIDTH-1:0] o_delta,
   output logic [31:0]            o_pos
);

   logic [COUNT_WIDTH-1:0] r_prev;

   // Modular subtraction makes counter wrap-around come out right.
   assign o_delta = i_q - r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= '0;
      end else if (init) begin
         r_prev <= '0;
      end else if (sample) begin
         r_prev <= i_q;
      end
   end

`ifdef ENCODER_SAMPLER_POS_ACCUM_EN
   logic [31:0] r_pos;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos <= '0;
      end else if (init) begin
         r_pos <= '0;
      end else if (sample) begin
         r_pos <= r_pos + 32'($signed(o_delta));
      end
   end

   assign o_pos = r_pos;
`else
   assign o_pos = '0;
`endif

endmodule

// File: rtl/encoder_sampler.sv
// -----------------------------------------------------------------------------
// encoder_sampler
// Sequencing controller for the dual-channel pulse counter. Drives the counter
// configuration word, runs the sample timer and delivers per-period signed
// count deltas over a valid/ready channel.
// Optional feature: ENCODER_SAMPLER_POS_ACCUM_EN enables the pos0/pos1
// position accumulators (tied to 0 when undefined).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start, stop  : one-cycle control pulses (stop wins)
//   mode, period : latched on start
//   Q0, Q1       : counter channel values
//   sel          : registered counter configuration word
//   overrun      : sticky, a sample was dropped
//   busy         : controller not idle
//   pos0, pos1   : accumulated positions
//   vel_if       : velocity valid/ready channel (master)
// -----------------------------------------------------------------------------
module encoder_sampler
   import encoder_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic [1:0]             mode,
   input  logic [31:0]            period,
   input  logic [COUNT_WIDTH-1:0] Q0,
   input  logic [COUNT_WIDTH-1:0] Q1,
   output logic [SEL_WIDTH-1:0]   sel,
   output logic                   overrun,
   output logic                   busy,
   output logic [31:0]            pos0,
   output logic [31:0]            pos1,
   encoder_sampler_if.master      vel_if
);

   state_e                 r_state;
   logic [31:0]            r_timer;
   logic [31:0]            r_period;
   logic [1:0]             r_mode;
   logic [SEL_WIDTH-1:0]   r_sel;
   logic                   r_busy;
   logic                   r_overrun;
   logic [COUNT_WIDTH-1:0] r_vel0;
   logic [COUNT_WIDTH-1:0] r_vel1;
   logic                   r_vel_valid;

   logic [31:0]            w_reload;
   logic                   w_sample;
   logic                   w_load;
   logic                   w_init;
   logic [COUNT_WIDTH-1:0] w_delta0;
   logic [COUNT_WIDTH-1:0] w_delta1;

   // A period of 0 behaves as 1, i.e. a sample every cycle.
   assign w_reload = (r_period == 32'd0) ? 32'd0 : r_period - 32'd1;
   assign w_sample = (r_state == StRun) && (r_timer == 32'd0) && !start && !stop;
   assign w_load   = w_sample && (!r_vel_valid || vel_if.vel_ready);
   // prev/accumulators clear on an accepted start and again on entry to RUN.
   assign w_init   = !stop && (start || r_state == StSettle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_timer   <= '0;
         r_period  <= '0;
         r_mode    <= '0;
         r_sel     <= '0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         // sel trails the state by one cycle, except that stop drops the
         // enables together with busy.
         r_sel <= sel_word(r_state, r_mode);
         if (stop) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_sel   <= sel_word(StIdle, r_mode);
         end else if (start) begin
            r_state   <= StClear;
            r_busy    <= 1'b1;
            r_mode    <= mode;
            r_period  <= period;
            r_overrun <= 1'b0;
         end else begin
            case (r_state)
               StIdle: ;
               StClear: r_state <= StSettle;
               StSettle: begin
                  r_state <= StRun;
                  r_timer <= w_reload;
               end
               StRun: begin
                  if (r_timer == 32'd0) begin
                     r_timer <= w_reload;
                     if (!w_load) begin
                        r_overrun <= 1'b1;
                     end
                  end else begin
                     r_timer <= r_timer - 32'd1;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   // Result register; deliberately independent of stop so a pending pair
   // survives until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vel0      <= '0;
         r_vel1      <= '0;
         r_vel_valid <= 1'b0;
      end else if (w_load) begin
         r_vel0      <= w_delta0;
         r_vel1      <= w_delta1;
         r_vel_valid <= 1'b1;
      end else if (vel_if.vel_ready) begin
         r_vel_valid <= 1'b0;
      end
   end

   enc_channel_delta #(
      .COUNT_WIDTH(COUNT_WIDTH)
   ) u_ch0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .sample  (w_sample),
      .init    (w_init),
      .i_q     (Q0),
      .o_delta (w_delta0),
      .o_pos   (pos0)
   );

   enc_channel_delta #(
      .COUNT_WIDTH(COUNT_WIDTH)
   ) u_ch1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .sample  (w_sample),
      .init    (w_init),
      .i_q     (Q1),
      .o_delta (w_delta1),
      .o_pos   (pos1)
   );

   assign sel              = r_sel;
   assign busy             = r_busy;
   assign overrun          = r_overrun;
   assign vel_if.vel0      = r_vel0;
   assign vel_if.vel1      = r_vel1;
   assign vel_if.vel_valid = r_vel_valid;

endmodule

// File: tb/tb_encoder_sampler.sv
// -----------------------------------------------------------------------------
// tb_encoder_sampler
// Directed bench for encoder_sampler. Cycle numbers in comments count from the
// cycle in which start is driven (cycle 0).
// -----------------------------------------------------------------------------
module tb_encoder_sampler;

   localparam int unsigned CW = 16;
`ifdef ENCODER_SAMPLER_POS_ACCUM_EN
   localparam bit POS_EN = 1'b1;
`else
   localparam bit POS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          stop;
   logic [1:0]    mode;
   logic [31:0]   period;
   logic [CW-1:0] Q0;
   logic [CW-1:0] Q1;
   logic [32:0]   sel;
   logic          overrun;
   logic          busy;
   logic [31:0]   pos0;
   logic [31:0]   pos1;
   bit            ramp;
   int            checks = 0;
   int            errors = 0;

   encoder_sampler_if #(.COUNT_WIDTH(CW)) vel_if ();

   encoder_sampler #(
      .COUNT_WIDTH(CW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .stop    (stop),
      .mode    (mode),
      .period  (period),
      .Q0      (Q0),
      .Q1      (Q1),
      .sel     (sel),
      .overrun (overrun),
      .busy    (busy),
      .pos0    (pos0),
      .pos1    (pos1),
      .vel_if  (vel_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; the counter model ramps Q0 by +3 and Q1 by -1.
   task automatic tick();
      @(posedge clk);
      #1;
      if (ramp) begin
         Q0 = Q0 + 16'd3;
         Q1 = Q1 - 16'd1;
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_sel"}, 64'(sel), 64'd0);
      chk({tag, "_vel0"}, 64'(vel_if.vel0), 64'd0);
      chk({tag, "_vel1"}, 64'(vel_if.vel1), 64'd0);
      chk({tag, "_valid"}, 64'(vel_if.vel_valid), 64'd0);
      chk({tag, "_overrun"}, 64'(overrun), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_pos0"}, 64'(pos0), 64'd0);
      chk({tag, "_pos1"}, 64'(pos1), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00; period = 32'd0;
      Q0 = '0; Q1 = '0; ramp = 1'b0; vel_if.vel_ready = 1'b1;
      tick_n(2);
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // ---- period 10, mode 01, ramping counters ----
      mode = 2'b01; period = 32'd10; start = 1'b1;
      tick(); start = 1'b0;                                  // cycle 1
      chk("busy_c1", 64'(busy), 64'd1);
      chk("sel_c1", 64'(sel), 64'h0);
      tick();                                                // cycle 2
      chk("sel_clear", 64'(sel), 64'h31);
      Q0 = '0; Q1 = '0; ramp = 1'b1;
      tick();                                                // cycle 3
      chk("sel_run", 64'(sel), 64'h0D);
      tick_n(9);                                             // cycle 12
      chk("valid_c12", 64'(vel_if.vel_valid), 64'd0);
      tick();                                                // cycle 13
      chk("valid_c13", 64'(vel_if.vel_valid), 64'd1);
      chk("vel0_s1", 64'(vel_if.vel0), 64'd30);
      chk("vel1_s1", 64'(vel_if.vel1), 64'hFFF6);
      chk("pos0_s1", 64'(pos0), POS_EN ? 64'd30 : 64'd0);
      chk("pos1_s1", 64'(pos1), POS_EN ? 64'hFFFF_FFF6 : 64'd0);
      tick();                                                // cycle 14
      chk("valid_c14", 64'(vel_if.vel_valid), 64'd0);
      tick_n(9);                                             // cycle 23
      chk("valid_c23", 64'(vel_if.vel_valid), 64'd1);
      chk("vel0_s2", 64'(vel_if.vel0), 64'd30);
      chk("vel1_s2", 64'(vel_if.vel1), 64'hFFF6);
      chk("pos0_s2", 64'(pos0), POS_EN ? 64'd60 : 64'd0);
      chk("pos1_s2", 64'(pos1), POS_EN ? 64'hFFFF_FFEC : 64'd0);

      // ---- wrap-around: prev0 0x003C -> 0xFFFA -> 0x0004 ----
      ramp = 1'b0; Q0 = 16'hFFFA; Q1 = 16'hFFEC;
      tick_n(10);                                            // cycle 33
      chk("vel0_neg", 64'(vel_if.vel0), 64'hFFBE);
      chk("vel1_zero", 64'(vel_if.vel1), 64'h0);
      chk("pos0_neg", 64'(pos0), POS_EN ? 64'hFFFF_FFFA : 64'd0);
      Q0 = 16'h0004;
      tick_n(10);                                            // cycle 43
      chk("vel0_wrap", 64'(vel_if.vel0), 64'd10);
      chk("valid_wrap", 64'(vel_if.vel_valid), 64'd1);
      chk("pos0_wrap", 64'(pos0), POS_EN ? 64'd4 : 64'd0);
      chk("overrun_pre", 64'(overrun), 64'd0);

      // ---- overrun: consumer stalls across the sample at cycle 52 ----
      vel_if.vel_ready = 1'b0; Q0 = 16'h0014;
      tick_n(10);                                            // cycle 53
      chk("vel0_held", 64'(vel_if.vel0), 64'd10);
      chk("valid_held", 64'(vel_if.vel_valid), 64'd1);
      chk("overrun_set", 64'(overrun), 64'd1);
      chk("pos0_drop", 64'(pos0), POS_EN ? 64'h14 : 64'd0);
      Q0 = 16'h0019;
      tick_n(9);                                             // cycle 62
      vel_if.vel_ready = 1'b1;
      tick();                                                // cycle 63
      chk("vel0_after_ovr", 64'(vel_if.vel0), 64'd5);
      chk("valid_after_ovr", 64'(vel_if.vel_valid), 64'd1);
      chk("overrun_sticky", 64'(overrun), 64'd1);
      chk("pos0_after_ovr", 64'(pos0), POS_EN ? 64'h19 : 64'd0);

      // ---- stop with a result pending ----
      vel_if.vel_ready = 1'b0; stop = 1'b1;
      tick(); stop = 1'b0;
      chk("busy_stop", 64'(busy), 64'd0);
      chk("sel_stop", 64'(sel), 64'h01);
      chk("valid_stop", 64'(vel_if.vel_valid), 64'd1);
      chk("vel0_stop", 64'(vel_if.vel0), 64'd5);
      tick_n(3);
      chk("valid_pending", 64'(vel_if.vel_valid), 64'd1);
      vel_if.vel_ready = 1'b1;
      tick();
      chk("valid_taken", 64'(vel_if.vel_valid), 64'd0);

      // ---- start and stop together: stays idle ----
      start = 1'b1; stop = 1'b1;
      tick(); start = 1'b0; stop = 1'b0;
      chk("busy_ss1", 64'(busy), 64'd0);
      tick();
      chk("busy_ss2", 64'(busy), 64'd0);
      chk("sel_ss2", 64'(sel), 64'h01);

      // ---- asynchronous reset mid-RUN with a result pending ----
      mode = 2'b10; period = 32'd10; vel_if.vel_ready = 1'b0; start = 1'b1;
      tick(); start = 1'b0;                                  // cycle 1
      chk("overrun_cleared", 64'(overrun), 64'd0);
      tick_n(12);                                            // cycle 13
      chk("valid_rst_pre", 64'(vel_if.vel_valid), 64'd1);
      chk("vel0_rst_pre", 64'(vel_if.vel0), 64'h19);
      chk("vel1_rst_pre", 64'(vel_if.vel1), 64'hFFEC);
      chk("sel_rst_pre", 64'(sel), 64'h0E);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      tick();
      rst_n = 1'b1;

      // ---- period 0: a sample every cycle from cycle 3 ----
      vel_if.vel_ready = 1'b1; period = 32'd0; mode = 2'b00; start = 1'b1;
      tick(); start = 1'b0;                                  // cycle 1
      tick();                                                // cycle 2
      Q0 = '0; Q1 = '0; ramp = 1'b1;
      tick();                                                // cycle 3
      chk("sel_p0", 64'(sel), 64'h0C);
      chk("valid_p0_c3", 64'(vel_if.vel_valid), 64'd0);
      tick();                                                // cycle 4
      chk("valid_p0_c4", 64'(vel_if.vel_valid), 64'd1);
      chk("vel0_p0_c4", 64'(vel_if.vel0), 64'd3);
      chk("vel1_p0_c4", 64'(vel_if.vel1), 64'hFFFF);
      tick();                                                // cycle 5
      chk("valid_p0_c5", 64'(vel_if.vel_valid), 64'd1);
      chk("vel0_p0_c5", 64'(vel_if.vel0), 64'd3);
      chk("vel1_p0_c5", 64'(vel_if.vel1), 64'hFFFF);
      chk("pos0_p0_c5", 64'(pos0), POS_EN ? 64'd6 : 64'd0);
      chk("pos1_p0_c5", 64'(pos1), POS_EN ? 64'hFFFF_FFFE : 64'd0);

      ramp = 1'b0; stop = 1'b1;
      tick(); stop = 1'b0;
      chk("busy_end", 64'(busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
